// File: rtl/fetch_sequencer.sv
// Fetch/decode/indirect timing sequencer for the basic computer: drives PC/AR/IR
// commands, bus select and memory read, and hands off to the execute unit.
module fetch_sequencer #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          resume,
  input  logic          halt,
  input  logic [DW-1:0] ir_in,
  input  logic          exec_done,
  output logic          pc_load,
  output logic          pc_inc,
  output logic          pc_clr,
  output logic          ar_load,
  output logic          ar_inc,
  output logic          ar_clr,
  output logic          ir_load,
  output logic          mem_read,
  output logic [2:0]    bus_sel,
  output logic [3:0]    sc,
  output logic          exec_start,
  output logic [2:0]    opcode,
  output logic          indirect,
  output logic          running
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_T0, S_T1, S_T2, S_T3, S_EXEC
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  state_t     state_reg, state_next;
  logic [3:0] sc_reg, sc_next;
  logic       halt_pending_reg, halt_pending_next;
  logic [2:0] opcode_reg, opcode_next;
  logic       indirect_reg, indirect_next;

  // The address field is carried by IR but consumed by AR, not by the sequencer.
  logic unused_addr;
  assign unused_addr = ^ir_in[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      sc_reg           <= 4'd0;
      halt_pending_reg <= 1'b0;
      opcode_reg       <= 3'd0;
      indirect_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sc_reg           <= sc_next;
      halt_pending_reg <= halt_pending_next;
      opcode_reg       <= opcode_next;
      indirect_reg     <= indirect_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    sc_next           = sc_reg;
    halt_pending_next = halt_pending_reg | ((state_reg != S_IDLE) & halt);
    opcode_next       = opcode_reg;
    indirect_next     = indirect_reg;
    case (state_reg)
      S_IDLE: begin
        sc_next           = 4'd0;
        halt_pending_next = 1'b0;
        if (start) begin
          // start together with halt runs exactly one instruction
          halt_pending_next = halt;
          state_next        = resume ? S_T0 : S_INIT;
        end
      end
      S_INIT: begin
        state_next = S_T0;
        sc_next    = 4'd0;
      end
      S_T0: begin
        state_next = S_T1;
        sc_next    = 4'd1;
      end
      S_T1: begin
        state_next = S_T2;
        sc_next    = 4'd2;
      end
      S_T2: begin
        state_next    = S_T3;
        sc_next       = 4'd3;
        opcode_next   = ir_in[DW-2:DW-4];
        indirect_next = ir_in[DW-1];
      end
      S_T3: begin
        state_next = S_EXEC;
        sc_next    = 4'd4;
      end
      S_EXEC: begin
        if (exec_done) begin
          sc_next = 4'd0;
          if (halt_pending_next) begin
            state_next        = S_IDLE;
            halt_pending_next = 1'b0;
          end else begin
            state_next = S_T0;
          end
        end else if (sc_reg != 4'd15) begin
          sc_next = sc_reg + 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        sc_next    = 4'd0;
      end
    endcase
  end

  // Moore command decode; sc stays at 4 only in the first EXEC cycle.
  always_comb begin
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_clr     = 1'b0;
    ar_load    = 1'b0;
    ar_inc     = 1'b0;
    ar_clr     = 1'b0;
    ir_load    = 1'b0;
    mem_read   = 1'b0;
    bus_sel    = BUS_NONE;
    exec_start = 1'b0;
    running    = (state_reg != S_IDLE);
    case (state_reg)
      S_INIT: begin
        pc_clr = 1'b1;
        ar_clr = 1'b1;
      end
      S_T0: begin
        bus_sel = BUS_PC;
        ar_load = 1'b1;
      end
      S_T1: begin
        mem_read = 1'b1;
        bus_sel  = BUS_MEM;
        ir_load  = 1'b1;
        pc_inc   = 1'b1;
      end
      S_T2: begin
        bus_sel = BUS_IR;
        ar_load = 1'b1;
      end
      S_T3: begin
        // opcode 7 uses the I bit as an instruction-class flag, not indirection
        if (indirect_reg && opcode_reg != 3'b111) begin
          mem_read = 1'b1;
          bus_sel  = BUS_MEM;
          ar_load  = 1'b1;
        end
      end
      S_EXEC: exec_start = (sc_reg == 4'd4);
      default: ;
    endcase
  end

  assign sc       = sc_reg;
  assign opcode   = opcode_reg;
  assign indirect = indirect_reg;

endmodule
